// File: rtl/riot_pkg.sv
// riot_pkg: shared definitions for the riot_ports I/O and timer core.
//   - register offsets for the control/status part of the map
//   - prescaler encoding and its divide-value function
//   - bit positions inside the flags and control registers
package riot_pkg;

  // Address map (0x0..0x7 are the port data/DDR pairs)
  localparam logic [1:0] REG_LOAD_HI = 2'b10;  // A[3:2] of the 0x8..0xB timer-load window
  localparam logic [3:0] REG_TIMER   = 4'hC;
  localparam logic [3:0] REG_FLAGS   = 4'hD;
  localparam logic [3:0] REG_CTRL    = 4'hE;

  // Prescaler select, taken from A[1:0] of a timer load
  typedef enum logic [1:0] {
    PRE_DIV1    = 2'd0,
    PRE_DIV8    = 2'd1,
    PRE_DIV64   = 2'd2,
    PRE_DIV1024 = 2'd3
  } presc_e;

  // Flags register (0xD) bit positions
  localparam int FLAG_TF_BIT = 7;
  localparam int FLAG_EF_BIT = 6;

  // Control register (0xE) bit positions
  localparam int CTRL_TIE_BIT  = 0;
  localparam int CTRL_EIE_BIT  = 1;
  localparam int CTRL_EPOL_BIT = 2;

  // Number of phi2 cycles per timer tick for a given prescaler
  function automatic logic [10:0] div_value(input presc_e sel);
    case (sel)
      PRE_DIV1:    div_value = 11'd1;
      PRE_DIV8:    div_value = 11'd8;
      PRE_DIV64:   div_value = 11'd64;
      PRE_DIV1024: div_value = 11'd1024;
      default:     div_value = 11'd1024;
    endcase
  endfunction

endpackage

// File: rtl/riot_timer.sv
// riot_timer: 8-bit interval timer with selectable prescaler and timer flag.
// Ports:
//   clk, rst    phi2 clock, synchronous active-high reset
//   load_i      timer-load strobe (write to 0x8..0xB)
//   di_i        initial count for a load
//   sel_i       prescaler select for a load (presc_e encoding)
//   rd_clr_i    timer-read strobe (read of 0xC), clears TF
//   count_o     current count
//   tf_o        timer flag
module riot_timer
  import riot_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] di_i,
  input  logic [1:0] sel_i,
  input  logic       rd_clr_i,
  output logic [7:0] count_o,
  output logic       tf_o
);

  logic [7:0] count_q, count_d;
  logic [9:0] pre_q, pre_d;
  presc_e     sel_q, sel_d;
  logic       tf_q, tf_d;
  logic       tick_s;

  // Next-state: load beats everything; on underflow the flag set beats a read-clear
  always_comb begin
    tick_s  = ({1'b0, pre_q} == (div_value(sel_q) - 11'd1));
    count_d = count_q;
    pre_d   = pre_q;
    sel_d   = sel_q;
    tf_d    = tf_q;
    if (load_i) begin
      count_d = di_i;
      pre_d   = 10'd0;
      sel_d   = presc_e'(sel_i);
      tf_d    = 1'b0;
    end else begin
      if (rd_clr_i) begin
        tf_d = 1'b0;
      end else begin
        tf_d = tf_q;
      end
      if (tick_s) begin
        pre_d = 10'd0;
        if (count_q == 8'd0) begin
          // Underflow: wrap, flag, and keep ticking every cycle until reloaded
          count_d = 8'hFF;
          tf_d    = 1'b1;
          sel_d   = PRE_DIV1;
        end else begin
          count_d = count_q - 8'd1;
        end
      end else begin
        pre_d = pre_q + 10'd1;
      end
    end
  end

  // Timer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 8'd0;
      pre_q   <= 10'd0;
      sel_q   <= PRE_DIV1024;
      tf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      sel_q   <= sel_d;
      tf_q    <= tf_d;
    end
  end

  assign count_o = count_q;
  assign tf_o    = tf_q;

endmodule

// File: rtl/riot_ports.sv
// riot_ports: parametrised RIOT-style core with 1..4 bidirectional ports,
// an interval timer and an edge-detect interrupt.
// Ports:
//   phi2, rst   clock, synchronous active-high reset
//   cs, we_n    chip select, 0 = write / 1 = read
//   A, DI       register address, write data
//   DO, OE      read data (combinational), output enable (cs & we_n)
//   PI          pin inputs, port p at [p*WIDTH +: WIDTH]
//   PO, DDR     port output and direction registers (1 = drive)
//   irq_n       registered active-low interrupt
module riot_ports
  import riot_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int WIDTH  = 8
) (
  input  logic                    phi2,
  input  logic                    rst,
  input  logic                    cs,
  input  logic                    we_n,
  input  logic [3:0]              A,
  input  logic [7:0]              DI,
  output logic [7:0]              DO,
  output logic                    OE,
  input  logic [NPORTS*WIDTH-1:0] PI,
  output logic [NPORTS*WIDTH-1:0] PO,
  output logic [NPORTS*WIDTH-1:0] DDR,
  output logic                    irq_n
);

  logic [WIDTH-1:0] po_q [NPORTS];
  logic [WIDTH-1:0] po_d [NPORTS];
  logic [WIDTH-1:0] ddr_q [NPORTS];
  logic [WIDTH-1:0] ddr_d [NPORTS];
  logic [2:0]       ctrl_q, ctrl_d;
  logic             prev_q, prev_d;
  logic             ef_q, ef_d;
  logic             irq_q, irq_d;

  // Four-entry views so that absent ports decode as all-zero
  logic [WIDTH-1:0] pi_v_s  [4];
  logic [WIDTH-1:0] po_v_s  [4];
  logic [WIDTH-1:0] ddr_v_s [4];

  logic       wr_s, rd_s, port_wr_s, load_s, tmr_rd_s, flg_rd_s;
  logic       edge_src_s, edge_s;
  logic [7:0] count_s, port_rd_s, flags_s;
  logic       tf_s;

  assign wr_s      = cs & ~we_n;
  assign rd_s      = cs & we_n;
  assign OE        = rd_s;
  assign port_wr_s = wr_s & ~A[3];
  assign load_s    = wr_s & (A[3:2] == REG_LOAD_HI);
  assign tmr_rd_s  = rd_s & (A == REG_TIMER);
  assign flg_rd_s  = rd_s & (A == REG_FLAGS);

  for (genvar gp = 0; gp < 4; gp++) begin : g_view
    if (gp < NPORTS) begin : g_live
      assign pi_v_s[gp]                = PI[gp*WIDTH +: WIDTH];
      assign po_v_s[gp]                = po_q[gp];
      assign ddr_v_s[gp]               = ddr_q[gp];
      assign PO[gp*WIDTH +: WIDTH]     = po_q[gp];
      assign DDR[gp*WIDTH +: WIDTH]    = ddr_q[gp];
    end else begin : g_absent
      assign pi_v_s[gp]  = '0;
      assign po_v_s[gp]  = '0;
      assign ddr_v_s[gp] = '0;
    end
  end

  riot_timer u_timer (
    .clk      (phi2),
    .rst      (rst),
    .load_i   (load_s),
    .di_i     (DI),
    .sel_i    (A[1:0]),
    .rd_clr_i (tmr_rd_s),
    .count_o  (count_s),
    .tf_o     (tf_s)
  );

  // Port register writes: even address = data, odd address = DDR
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      if (port_wr_s && (int'(A[2:1]) == p) && A[0]) begin
        ddr_d[p] = DI[WIDTH-1:0];
      end else begin
        ddr_d[p] = ddr_q[p];
      end
      if (port_wr_s && (int'(A[2:1]) == p) && !A[0]) begin
        po_d[p] = DI[WIDTH-1:0];
      end else begin
        po_d[p] = po_q[p];
      end
    end
  end

  // Control, edge flag and interrupt next-state
  always_comb begin
    edge_src_s = pi_v_s[0][WIDTH-1];
    prev_d     = edge_src_s;
    if (ctrl_q[CTRL_EPOL_BIT]) begin
      edge_s = edge_src_s & ~prev_q;
    end else begin
      edge_s = ~edge_src_s & prev_q;
    end
    if (wr_s && (A == REG_CTRL)) begin
      ctrl_d = DI[2:0];
    end else begin
      ctrl_d = ctrl_q;
    end
    // A new edge outranks the read-clear of the same cycle
    if (edge_s) begin
      ef_d = 1'b1;
    end else if (flg_rd_s) begin
      ef_d = 1'b0;
    end else begin
      ef_d = ef_q;
    end
    irq_d = ~((tf_s & ctrl_q[CTRL_TIE_BIT]) | (ef_q & ctrl_q[CTRL_EIE_BIT]));
  end

  // Port read value: driven bits from PO, input bits from the pins
  always_comb begin
    port_rd_s = 8'h00;
    if (A[0]) begin
      port_rd_s[WIDTH-1:0] = ddr_v_s[A[2:1]];
    end else begin
      port_rd_s[WIDTH-1:0] = (po_v_s[A[2:1]] & ddr_v_s[A[2:1]])
                           | (pi_v_s[A[2:1]] & ~ddr_v_s[A[2:1]]);
    end
  end

  // Read data mux
  always_comb begin
    flags_s              = 8'h00;
    flags_s[FLAG_TF_BIT] = tf_s;
    flags_s[FLAG_EF_BIT] = ef_q;
    if (!A[3]) begin
      DO = port_rd_s;
    end else begin
      case (A)
        REG_TIMER: DO = count_s;
        REG_FLAGS: DO = flags_s;
        REG_CTRL:  DO = {5'b00000, ctrl_q};
        default:   DO = 8'h00;
      endcase
    end
  end

  // Port, control, edge and interrupt registers
  always_ff @(posedge phi2) begin
    if (rst) begin
      for (int p = 0; p < NPORTS; p++) begin
        po_q[p]  <= '0;
        ddr_q[p] <= '0;
      end
      ctrl_q <= 3'b000;
      prev_q <= 1'b0;
      ef_q   <= 1'b0;
      irq_q  <= 1'b1;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        po_q[p]  <= po_d[p];
        ddr_q[p] <= ddr_d[p];
      end
      ctrl_q <= ctrl_d;
      prev_q <= prev_d;
      ef_q   <= ef_d;
      irq_q  <= irq_d;
    end
  end

  assign irq_n = irq_q;

endmodule

// File: tb/tb_riot_ports.sv
module tb_riot_ports;

  logic        phi2 = 1'b0;
  logic        rst, cs, we_n;
  logic [3:0]  A;
  logic [7:0]  DI, DO, DO2;
  logic        OE, OE2, irq_n, irq2_n;
  logic [15:0] PI, PO, DDR;
  logic [3:0]  PI2, PO2, DDR2;

  int tests = 0;
  int fails = 0;

  always #10 phi2 = ~phi2;

  riot_ports #(.NPORTS(2), .WIDTH(8)) dut (
    .phi2(phi2), .rst(rst), .cs(cs), .we_n(we_n), .A(A), .DI(DI), .DO(DO),
    .OE(OE), .PI(PI), .PO(PO), .DDR(DDR), .irq_n(irq_n));

  riot_ports #(.NPORTS(1), .WIDTH(4)) dut_small (
    .phi2(phi2), .rst(rst), .cs(cs), .we_n(we_n), .A(A), .DI(DI), .DO(DO2),
    .OE(OE2), .PI(PI2), .PO(PO2), .DDR(DDR2), .irq_n(irq2_n));

  // ---------------- behavioural reference model (default instance) ----------------
  int m_po [2];
  int m_ddr[2];
  int m_ctrl, m_cnt, m_pre, m_div, m_tf, m_ef, m_prev, m_irq;
  int divtab[4] = '{1, 8, 64, 1024};

  always @(posedge phi2) begin : model
    int  n_cnt, n_pre, n_div, n_tf, n_ef, cur, p;
    bit  wr, rd, edge_seen;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_po[i]  <= 0;
        m_ddr[i] <= 0;
      end
      m_ctrl <= 0; m_cnt <= 0; m_pre <= 0; m_div <= 1024;
      m_tf <= 0; m_ef <= 0; m_prev <= 0; m_irq <= 1;
    end else begin
      wr = cs && !we_n;
      rd = cs && we_n;
      n_cnt = m_cnt; n_div = m_div; n_tf = m_tf;
      if (rd && A == 4'hC) n_tf = 0;
      if (m_pre == m_div - 1) begin
        n_pre = 0;
        if (m_cnt == 0) begin n_cnt = 255; n_tf = 1; n_div = 1; end
        else n_cnt = m_cnt - 1;
      end else begin
        n_pre = m_pre + 1;
      end
      if (wr && A >= 4'h8 && A <= 4'hB) begin
        n_cnt = DI; n_pre = 0; n_div = divtab[A - 4'h8]; n_tf = 0;
      end
      cur = PI[7];
      edge_seen = (m_ctrl & 4) ? (m_prev == 0 && cur == 1) : (m_prev == 1 && cur == 0);
      n_ef = m_ef;
      if (rd && A == 4'hD) n_ef = 0;
      if (edge_seen) n_ef = 1;
      m_irq <= ((m_tf && (m_ctrl & 1)) || (m_ef && (m_ctrl & 2))) ? 0 : 1;
      if (wr && A < 4'h8) begin
        p = int'(A) / 2;
        if (p < 2) begin
          if (A[0]) m_ddr[p] <= DI; else m_po[p] <= DI;
        end
      end
      if (wr && A == 4'hE) m_ctrl <= DI & 7;
      m_cnt <= n_cnt; m_pre <= n_pre; m_div <= n_div; m_tf <= n_tf; m_ef <= n_ef;
      m_prev <= cur;
    end
  end

  function automatic int model_do(input logic [3:0] a, input logic [15:0] pi);
    int p, piv;
    if (a < 4'h4) begin
      p   = int'(a) / 2;
      piv = int'(pi >> (8 * p)) & 255;
      if (a[0]) return m_ddr[p];
      return (m_po[p] & m_ddr[p]) | (piv & ~m_ddr[p] & 255);
    end
    if (a == 4'hC) return m_cnt;
    if (a == 4'hD) return m_tf * 128 + m_ef * 64;
    if (a == 4'hE) return m_ctrl;
    return 0;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clk_edge();
    @(posedge phi2);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) clk_edge();
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cs = 1'b1; we_n = 1'b0; A = a; DI = d;
    clk_edge();
    cs = 1'b0; we_n = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    cs = 1'b1; we_n = 1'b1; A = a;
    #1;
    d = DO;
    clk_edge();
    cs = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [7:0] d);
    A = a;
    #1;
    d = DO;
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  a;
    logic [7:0]  di;
    logic [15:0] pi;
    logic [7:0]  exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic w, input logic [3:0] a, input logic [7:0] di,
                     input logic [15:0] pi, input logic [7:0] exp);
    vec_t v;
    v.wr = w; v.a = a; v.di = di; v.pi = pi; v.exp = exp;
    tbl.push_back(v);
  endtask

  logic [7:0] d;

  initial begin
    rst = 1'b1; cs = 1'b0; we_n = 1'b1; A = 4'h0; DI = 8'h00; PI = 16'h0000; PI2 = 4'h0;
    idle(2);
    rst = 1'b0;

    check("reset_irq_n", irq_n, 1'b1);
    check("reset_po", PO, 16'h0000);
    check("reset_ddr", DDR, 16'h0000);

    // Reset reads of every address, then the port mix and register-map vectors
    for (int a = 0; a < 16; a++) add(1'b0, 4'(a), 8'h00, 16'h0000, 8'h00);
    add(1'b1, 4'h1, 8'hF0, 16'h0055, 8'h00);
    add(1'b1, 4'h0, 8'hAA, 16'h0055, 8'h00);
    add(1'b0, 4'h0, 8'h00, 16'h0055, 8'hA5);
    add(1'b0, 4'h1, 8'h00, 16'h0055, 8'hF0);
    add(1'b1, 4'h3, 8'h0F, 16'h9955, 8'h00);
    add(1'b1, 4'h2, 8'h3C, 16'h9955, 8'h00);
    add(1'b0, 4'h2, 8'h00, 16'h9955, 8'h9C);
    add(1'b0, 4'h3, 8'h00, 16'h9955, 8'h0F);
    add(1'b0, 4'h0, 8'h00, 16'h9955, 8'hA5);
    add(1'b1, 4'h5, 8'hFF, 16'h9955, 8'h00);
    add(1'b0, 4'h5, 8'h00, 16'h9955, 8'h00);
    add(1'b0, 4'h4, 8'h00, 16'h9955, 8'h00);
    add(1'b1, 4'hE, 8'hF8, 16'h9955, 8'h00);
    add(1'b0, 4'hE, 8'h00, 16'h9955, 8'h00);
    add(1'b1, 4'hE, 8'h05, 16'h9955, 8'h00);
    add(1'b0, 4'hE, 8'h00, 16'h9955, 8'h05);
    add(1'b1, 4'hD, 8'hFF, 16'h9955, 8'h00);
    add(1'b0, 4'hD, 8'h00, 16'h9955, 8'h00);
    add(1'b1, 4'hF, 8'hFF, 16'h9955, 8'h00);
    add(1'b0, 4'hF, 8'h00, 16'h9955, 8'h00);
    add(1'b0, 4'h8, 8'h00, 16'h9955, 8'h00);
    add(1'b1, 4'hE, 8'h00, 16'h9955, 8'h00);

    foreach (tbl[i]) begin
      PI = tbl[i].pi;
      if (tbl[i].wr) begin
        wr(tbl[i].a, tbl[i].di);
      end else begin
        rd(tbl[i].a, d);
        check($sformatf("vec%0d_rd_%0h", i, tbl[i].a), d, tbl[i].exp);
      end
    end
    check("portmix_po", PO, 16'h3CAA);
    check("portmix_ddr", DDR, 16'h0FF0);

    // OE follows cs & we_n
    cs = 1'b1; we_n = 1'b1; A = 4'hF; #1;
    check("oe_read", OE, 1'b1);
    we_n = 1'b0; #1;
    check("oe_write", OE, 1'b0);
    cs = 1'b0; we_n = 1'b1;
    clk_edge();

    // Timer divide-by-8 from count 3 with TIE
    wr(4'hE, 8'h01);
    wr(4'h9, 8'h03);
    idle(7);  peek(4'hC, d); check("t8_cyc7_count", d, 8'h03);
    idle(1);  peek(4'hC, d); check("t8_cyc8_count", d, 8'h02);
    idle(24); peek(4'hC, d); check("t8_cyc32_count", d, 8'hFF);
    peek(4'hD, d); check("t8_cyc32_tf", d, 8'h80);
    check("t8_cyc32_irq_n", irq_n, 1'b1);
    idle(1);  peek(4'hC, d); check("t8_cyc33_count", d, 8'hFE);
    check("t8_cyc33_irq_n", irq_n, 1'b0);

    // Timer read on the underflow edge: TF stays set, next read clears it
    wr(4'h8, 8'h02);
    idle(2);
    rd(4'hC, d); check("race_rd_count", d, 8'h00);
    peek(4'hD, d); check("race_rd_tf_kept", d, 8'h80);
    peek(4'hC, d); check("race_rd_wrap", d, 8'hFF);
    rd(4'hC, d);
    peek(4'hD, d); check("race_rd_tf_cleared", d, 8'h00);

    // Reload on the underflow edge: load wins, TF stays clear
    wr(4'h8, 8'h02);
    idle(2);
    wr(4'h8, 8'h05);
    peek(4'hD, d); check("race_ld_tf", d, 8'h00);
    peek(4'hC, d); check("race_ld_count", d, 8'h05);

    // Edge detect, falling polarity
    wr(4'hB, 8'hFF);
    wr(4'hE, 8'h02);
    PI = 16'h0080;
    idle(2);
    peek(4'hD, d); check("edge_rise_ignored", d, 8'h00);
    PI = 16'h0000;
    clk_edge();
    peek(4'hD, d); check("edge_fall_ef", d, 8'h40);
    check("edge_irq_lag", irq_n, 1'b1);
    clk_edge();
    check("edge_irq_low", irq_n, 1'b0);
    rd(4'hD, d); check("edge_flags_rd", d, 8'h40);
    peek(4'hD, d); check("edge_ef_cleared", d, 8'h00);
    clk_edge();
    check("edge_irq_release", irq_n, 1'b1);
    PI = 16'h0080;
    idle(2);
    peek(4'hD, d); check("edge_rise_no_ef", d, 8'h00);
    // Flags read in the same cycle as a new edge
    PI = 16'h0000;
    rd(4'hD, d); check("edge_rd_pre_value", d, 8'h00);
    peek(4'hD, d); check("edge_set_wins", d, 8'h40);
    clk_edge();
    check("edge_irq_pending", irq_n, 1'b0);

    // Reset with a pending interrupt and modified state
    rst = 1'b1;
    clk_edge();
    rst = 1'b0;
    check("rst2_irq_n", irq_n, 1'b1);
    check("rst2_po", PO, 16'h0000);
    check("rst2_ddr", DDR, 16'h0000);
    peek(4'hD, d); check("rst2_flags", d, 8'h00);
    peek(4'hE, d); check("rst2_ctrl", d, 8'h00);
    peek(4'hC, d); check("rst2_count", d, 8'h00);

    // One 4-bit port: absent port ignored, upper data bits read 0
    wr(4'h2, 8'hFF);
    wr(4'h3, 8'hFF);
    wr(4'h0, 8'hFF);
    wr(4'h1, 8'h03);
    PI2 = 4'h5;
    A = 4'h2; #1; check("small_rd2", DO2, 8'h00);
    A = 4'h3; #1; check("small_rd3", DO2, 8'h00);
    A = 4'h0; #1; check("small_data0", DO2, 8'h07);
    A = 4'h1; #1; check("small_ddr0", DO2, 8'h03);
    check("small_po", PO2, 4'hF);
    check("small_ddr", DDR2, 4'h3);

    // Randomized traffic against the reference model
    rst = 1'b1;
    clk_edge();
    rst = 1'b0;
    for (int i = 0; i < 800; i++) begin
      rst  = ($urandom_range(0, 149) == 0);
      cs   = 1'($urandom_range(0, 1));
      we_n = 1'($urandom_range(0, 1));
      A    = 4'($urandom_range(0, 15));
      DI   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      PI   = 16'($urandom);
      PI2  = 4'($urandom);
      #1;
      check("rnd_do", DO, model_do(A, PI));
      check("rnd_po", PO, (m_po[1] << 8) | m_po[0]);
      check("rnd_ddr", DDR, (m_ddr[1] << 8) | m_ddr[0]);
      check("rnd_irq_n", irq_n, m_irq);
      clk_edge();
    end
    rst = 1'b0; cs = 1'b0; we_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/riot_ports.md
# riot_ports

Parametrised RIOT-style I/O and timer core: the successor to the fixed two-port 6530 core. It provides 1–4 bidirectional ports, each with its own data-direction register, an interval timer with four selectable prescalers, and an edge-detect interrupt. It sits behind the FPGA pad wrapper, which registers address, data and port pins on `phi2`; this block owns all register state and produces the data bus, output enables and IRQ.

## Interface
Parameters:
- `NPORTS`, 2: number of ports, legal range 1..4.
- `WIDTH`, 8: bits per port, legal range 1..8. When `WIDTH` < 8, upper `DO` bits read 0 and upper `DI` bits are ignored.

Ports:
- `phi2`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cs`  in  1  chip select, active-high.
- `we_n`  in  1  0 = write, 1 = read.
- `A`  in  4  register address.
- `DI`  in  8  write data.
- `DO`  out  8  read data, combinational from current state and `A`.
- `OE`  out  1  equals `cs & we_n`.
- `PI`  in  `NPORTS*WIDTH`  pin inputs; port p occupies bits [p*WIDTH +: WIDTH].
- `PO`  out  `NPORTS*WIDTH`  output registers.
- `DDR`  out  `NPORTS*WIDTH`  direction registers; 1 = drive.
- `irq_n`  out  1  interrupt, active-low.

## Operation
Register map. All writes occur on the edge where `cs & ~we_n`. Read side effects occur on the edge where `cs & we_n`.
- `0x0..0x7`: port p uses `2p` for data and `2p+1` for DDR.
  - Data read returns `(PO & DDR) | (PI & ~DDR)` per bit.
  - DDR read returns DDR.
  - For p ≥ `NPORTS`, reads return 0 and writes are ignored.
- `0x8..0xB`, write only: load timer with `DI` and select prescaler `A[1:0]`: 0 → ÷1, 1 → ÷8, 2 → ÷64, 3 → ÷1024. The write also clears the timer flag (TF). Reads return 0.
- `0xC`, read: current timer count. Clears TF.
- `0xD`, read: flags, with bit7 = TF and bit6 = edge flag (EF). Clears EF. Writes are ignored.
- `0xE`, read/write control register:
  - bit0: TIE, timer IRQ enable.
  - bit1: EIE, edge IRQ enable.
  - bit2: EPOL, 1 = rising edge, 0 = falling edge.
  - Other bits read 0.
- `0xF`: reads 0; writes ignored.

Timer:
- A 10-bit prescale counter `pre` increments every cycle.
- A tick occurs when `pre` reaches div−1. For ÷1, every cycle is a tick. `pre` returns to 0 on each tick.
- On a tick, the count decrements.
- On a tick with count = 0: count becomes 0xFF, TF is set, and the divider is forced to ÷1 until the next load.
- A load sets count to `DI` and `pre` to 0. The first tick then occurs div cycles after the load edge.

Edge detect:
- Source is `PI[WIDTH-1]` of port 0, sampled regardless of DDR.
- A 1-bit delay register holds the previous sample.
- EF is set when the previous and current samples differ in the direction selected by EPOL.

Interrupt: `irq_n = ~((TF & TIE) | (EF & EIE))`, registered, so it updates one cycle after the flag changes.

## Timing
Reset values:
- `PO` = 0, `DDR` = 0 (all inputs), control = 0.
- count = 0, divider = ÷1024, `pre` = 0.
- TF = 0, EF = 0, edge delay register = 0.
- `irq_n` = 1.

Latencies:
- Writes are visible on `PO`, `DDR` and control the cycle after the write edge.
- `DO` reflects state in the same cycle as `A`.

Simultaneous events:
- Load and underflow in the same cycle: the load wins and TF ends 0.
- Timer read (0xC) and underflow in the same cycle: set wins and TF ends 1.
- Flags read (0xD) and an edge in the same cycle: EF ends 1.
- Flags read returns the pre-edge values.

Reset asserted mid-count or with a pending IRQ returns all state to reset values on that edge.

## Structure
Package `riot_pkg` holds:
- register offset constants;
- the prescale encoding and a divide-value function;
- flag and control bit positions.

Sub-module `riot_timer` contains the count, `pre`, divider select and TF. Its ports are:
- load strobe, `DI`, select;
- read-clear strobe;
- count out, TF out.

Port registers and edge detect stay in `riot_ports`.

## Test plan
- Reset, then read every address: all reads 0 except 0xC = 0x00; `irq_n` = 1; `PO` = 0; `DDR` = 0.
- Port mix: write DDR0 = 0xF0 and data0 = 0xAA with `PI` port 0 = 0x55. Required: read 0x0 = 0xA5 and `PO` = 0xAA.
- Timer ÷8: write 0x9 with 3, TIE set. Required:
  - count reads 2 at cycle 8 after the load edge;
  - count reads 0xFF and TF = 1 at cycle 32;
  - count reads 0xFE at cycle 33;
  - `irq_n` = 0 at cycle 33.
- Timer flag clear vs. underflow: reading 0xC on the underflow edge leaves TF = 1, and the next read clears it. A reload on the underflow edge leaves TF = 0.
- Edge detect: EPOL = 0, EIE = 1, drive `PI[7]` 1→0. Required:
  - EF = 1 and `irq_n` low the following cycle;
  - a read of 0xD returns 0x40 and clears EF;
  - a 0→1 transition leaves EF = 0.
- `NPORTS`=1, `WIDTH`=4: writes to 0x2/0x3 are ignored, reads of 0x2/0x3 return 0, and data0 reads have bits [7:4] = 0.
